// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide result unit.
//   State encoding (IDLE, BUSY), pending-op encoding (OP_DIV, OP_MUL),
//   default latencies and the width of the latency down-counter.
package hilo_pkg;

  localparam int unsigned CNT_W           = 6;
  localparam int unsigned DEF_DIV_LATENCY = 32;
  localparam int unsigned DEF_MUL_LATENCY = 4;

  // Legacy-compatible state constants
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  // Kind of operation whose result is pending
  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/hilo_lat_cnt.sv
// Latency down-counter for hilo_unit.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : start value
//   dec        : decrement by one, saturating at zero
//   value      : current count
//   zero       : value == 0
module hilo_lat_cnt
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/hilo.sv
// hilo_unit: HI/LO register pair with delayed multiply/divide write-back.
//   div_start/div_q/div_r/div_t : divide issue, quotient, remainder, divisor
//   mul_start/mul_hi/mul_lo     : multiply issue, product words
//   mthi/mtlo/wr_data           : direct writes to HI/LO
//   mfhi/mflo/rd_data           : combinational read (HI has priority)
//   busy  : an operation is pending
//   stall : a request arrived while busy; issuer must hold it
//   dz    : sticky divide-by-zero flag, cleared by dz_clr (set wins)
// Results are captured into pending registers at issue and land in HI/LO
// exactly LATENCY edges later. A zero divide still occupies the full
// divide latency but leaves HI/LO untouched.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] div_t,
  input  logic        mul_start,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall,
  output logic        dz,
  input  logic        dz_clr
);

  logic             state;
  logic [31:0]      hi, lo, hi_pend, lo_pend;
  logic             op;
  logic             zdiv;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             accept_div, accept_mul, done;
  logic [CNT_W-1:0] cnt_load_val;

  assign accept_div   = (state == IDLE) && div_start;
  assign accept_mul   = (state == IDLE) && mul_start && !div_start;
  assign done         = (state == BUSY) && (cnt_value == CNT_W'(1));
  assign cnt_load_val = accept_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);

  hilo_lat_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_div || accept_mul),
    .load_val (cnt_load_val),
    .dec      (state == BUSY),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      op      <= OP_DIV;
      zdiv    <= 1'b0;
    end else if (state == IDLE) begin
      if (accept_div) begin
        lo_pend <= div_q;
        hi_pend <= div_r;
        op      <= OP_DIV;
        zdiv    <= (div_t == '0);
        state   <= BUSY;
      end else if (accept_mul) begin
        hi_pend <= mul_hi;
        lo_pend <= mul_lo;
        op      <= OP_MUL;
        zdiv    <= 1'b0;
        state   <= BUSY;
      end else begin
        if (mthi) hi <= wr_data;
        if (mtlo) lo <= wr_data;
      end
    end else begin
      if (done) begin
        if (!((op == OP_DIV) && zdiv)) begin
          hi <= hi_pend;
          lo <= lo_pend;
        end
        state <= IDLE;
      end else if (cnt_zero) begin
        // Unreachable with a legal latency; keeps the FSM from sticking in BUSY
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz <= 1'b0;
    end else if (accept_div && (div_t == '0)) begin
      dz <= 1'b1;
    end else if (dz_clr) begin
      dz <= 1'b0;
    end
  end

  assign busy  = (state == BUSY);
  assign stall = busy && (mfhi || mflo || mthi || mtlo || div_start || mul_start);

  always_comb begin
    rd_data = '0;
    if (mfhi)      rd_data = hi;
    else if (mflo) rd_data = lo;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit (DIV_LATENCY=4, MUL_LATENCY=1).
// Expected HI/LO/latency are pushed to a scoreboard when an operation is
// issued and popped when busy drops.
module tb_hilo_unit;

  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start, mul_start, mthi, mtlo, mfhi, mflo, dz_clr;
  logic [31:0] div_q, div_r, div_t, mul_hi, mul_lo, wr_data;
  logic [31:0] rd_data;
  logic        busy, stall, dz;

  hilo_unit #(.DIV_LATENCY(DIV_LAT), .MUL_LATENCY(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_t     (div_t),
    .mul_start (mul_start),
    .mul_hi    (mul_hi),
    .mul_lo    (mul_lo),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wr_data   (wr_data),
    .mfhi      (mfhi),
    .mflo      (mflo),
    .rd_data   (rd_data),
    .busy      (busy),
    .stall     (stall),
    .dz        (dz),
    .dz_clr    (dz_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    div_start = 0; mul_start = 0; mthi = 0; mtlo = 0;
    mfhi = 0; mflo = 0; dz_clr = 0;
  endtask

  // Drive an issue request and push its expected outcome
  task automatic issue(input logic d, input logic m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] t);
    exp_t e;
    div_start = d;
    mul_start = m;
    if (d) begin
      div_q = a; div_r = b; div_t = t;
      e.lat = DIV_LAT;
      if (t != 0) begin m_hi = b; m_lo = a; end
    end else begin
      mul_hi = a; mul_lo = b;
      e.lat = MUL_LAT;
      m_hi = a; m_lo = b;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Read HI (with both reads asserted, HI wins) then LO
  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    mfhi = 1; mflo = 1;
    #1 check({tag, "_hi"}, rd_data, eh);
    mfhi = 0;
    #1 check({tag, "_lo"}, rd_data, el);
    mflo = 0;
  endtask

  task automatic start_edge();
    @(negedge clk);
    clear_inputs();
  endtask

  // Count busy cycles until completion, then compare against scoreboard
  task automatic complete(input string tag, input logic hold_mflo);
    exp_t e;
    int unsigned n = 0;
    if (hold_mflo) mflo = 1;
    while (busy === 1'b1 && n < 200) begin
      if (hold_mflo) check({tag, "_stall"}, 32'(stall), 32'd1);
      n++;
      @(negedge clk);
    end
    if (hold_mflo) begin
      check({tag, "_stall_end"}, 32'(stall), 32'd0);
      mflo = 0;
    end
    check({tag, "_sb"}, sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, n, e.lat);
      read_hilo(tag, e.hi, e.lo);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1;
    div_q = 0; div_r = 0; div_t = 0; mul_hi = 0; mul_lo = 0; wr_data = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(negedge clk);
    mfhi = 1;
    #1;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dz",    32'(dz),    32'd0);
    mfhi = 0;
    reset = 0;
    @(negedge clk);
    read_hilo("rst", 32'd0, 32'd0);

    // Basic divide: q=7 r=3 t=2
    issue(1, 0, 32'd7, 32'd3, 32'd2);
    start_edge();
    check("div1_busy", 32'(busy), 32'd1);
    complete("div1", 1'b0);

    // Standalone multiply
    issue(0, 1, 32'hDEADBEEF, 32'h12345678, 0);
    start_edge();
    complete("mul1", 1'b0);

    // mflo held through busy: stall every cycle, then new LO
    issue(1, 0, 32'd11, 32'd5, 32'd3);
    start_edge();
    complete("div_mflo", 1'b1);

    // Zero divide: dz sets, HI/LO untouched after full latency
    issue(1, 0, 32'd99, 32'd98, 32'd0);
    start_edge();
    check("zdiv_dz", 32'(dz), 32'd1);
    complete("zdiv", 1'b0);
    dz_clr = 1;
    @(negedge clk);
    dz_clr = 0;
    check("dz_clr", 32'(dz), 32'd0);
    dz_clr = 1;
    issue(1, 0, 32'd5, 32'd6, 32'd0);
    start_edge();
    check("dz_set_wins", 32'(dz), 32'd1);
    complete("zdiv2", 1'b0);

    // div and mul together: only the divide happens (divide latency)
    mul_hi = 32'h0BAD0BAD; mul_lo = 32'h0BADF00D;
    issue(1, 1, 32'd21, 32'd4, 32'd5);
    start_edge();
    complete("divmul", 1'b0);

    // mthi+mtlo in IDLE
    wr_data = 32'hA5A5A5A5; mthi = 1; mtlo = 1;
    @(negedge clk);
    mthi = 0; mtlo = 0;
    m_hi = 32'hA5A5A5A5; m_lo = 32'hA5A5A5A5;
    read_hilo("mt", 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Start beats simultaneous mthi/mtlo
    wr_data = 32'h11111111; mthi = 1; mtlo = 1;
    issue(0, 1, 32'h0000CAFE, 32'h0000BEEF, 0);
    start_edge();
    mfhi = 1;
    #1 check("mt_ignored", rd_data, 32'hA5A5A5A5);
    mfhi = 0;
    complete("mul_mt", 1'b0);

    // Back-to-back multiplies, request held until accepted
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      issue(0, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0);
      @(negedge clk);
      check("b2b_busy",  32'(busy),  32'd1);
      check("b2b_stall", 32'(stall), 32'd1);
      @(negedge clk);
      check("b2b_done", 32'(busy), 32'd0);
      check("b2b_sb", sb.size(), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        read_hilo("b2b", e.hi, e.lo);
      end
    end
    mul_start = 0;
    @(negedge clk);

    // Reset two cycles into a divide discards it
    issue(1, 0, 32'd50, 32'd60, 32'd7);
    start_edge();
    @(negedge clk);
    reset = 1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dz",   32'(dz),   32'd0);
    sb.delete();
    m_hi = 0; m_lo = 0;
    read_hilo("arst", 32'd0, 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    check("arst_late_busy", 32'(busy), 32'd0);
    read_hilo("arst_late", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter DIV_LATENCY, 32, cycles from div_start to HI/LO update; legal range 1..63.
REQ-002 Parameter MUL_LATENCY, 4, cycles from mul_start to HI/LO update; legal range 1..63.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 div_start  in  1  DIV issued this cycle.
REQ-007 div_q  in  32  quotient from divider stage.
REQ-008 div_r  in  32  remainder from divider stage.
REQ-009 div_t  in  32  divisor operand, for zero detection.
REQ-010 mul_start  in  1  MULT issued this cycle.
REQ-011 mul_hi  in  32  upper product word.
REQ-012 mul_lo  in  32  lower product word.
REQ-013 mthi  in  1  write wr_data to HI.
REQ-014 mtlo  in  1  write wr_data to LO.
REQ-015 wr_data  in  32  MTHI/MTLO data.
REQ-016 mfhi  in  1  read HI.
REQ-017 mflo  in  1  read LO.
REQ-018 rd_data  out  32  read data, combinational.
REQ-019 busy  out  1  operation pending.
REQ-020 stall  out  1  hold issuing stage this cycle.
REQ-021 dz  out  1  sticky divide-by-zero flag.
REQ-022 dz_clr  in  1  clear dz.

Function
REQ-023 States IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-024 In IDLE, div_start at edge k SHALL capture LO_pend=div_q and HI_pend=div_r, load the counter with DIV_LATENCY, and enter BUSY.
REQ-025 In IDLE, mul_start SHALL capture HI_pend=mul_hi and LO_pend=mul_lo and load MUL_LATENCY; div_start SHALL take priority when both are asserted, and the mul_start is dropped.
REQ-026 In BUSY, the counter SHALL decrement once per edge; at the edge where it goes from 1 to 0, HI/LO SHALL load the pending values and the state SHALL return to IDLE, so the update lands at edge k+LATENCY.
REQ-027 With div_t==0 at div_start, dz SHALL set at edge k, the full DIV_LATENCY SHALL elapse, and HI/LO SHALL remain unchanged at completion.
REQ-028 dz SHALL clear on dz_clr; a simultaneous set SHALL win.
REQ-029 stall SHALL equal busy AND (mfhi OR mflo OR mthi OR mtlo OR div_start OR mul_start).
REQ-030 Requests made during BUSY SHALL be ignored; the issuer holds them until stall deasserts.
REQ-031 In IDLE, mthi/mtlo SHALL write at the next edge; both may be asserted together.
REQ-032 In IDLE, a start request SHALL take priority and mthi/mtlo in the same cycle SHALL be ignored.
REQ-033 rd_data SHALL be HI if mfhi, else LO if mflo, else 0, with mfhi priority and no bypass of pending values.
REQ-034 A start issued in the cycle after completion SHALL be accepted normally, with no dead cycle.

Reset
REQ-035 Reset SHALL force IDLE, counter=0, HI=LO=0, HI_pend=LO_pend=0, dz=0, busy=0, and stall=0, and SHALL discard any in-flight operation.
REQ-036 Outputs SHALL be valid starting with the first edge after reset deasserts.

Structure
REQ-037 The shared package/include SHALL hold the state encoding (IDLE, BUSY), the op encoding (OP_DIV, OP_MUL), the default latencies, and the 6-bit counter width.
REQ-038 The down-counter SHALL be a sub-module hilo_lat_cnt (load, value, decrement, zero flag); all other logic stays in hilo_unit.

Verification
REQ-039 Bench: div_start with q=7, r=3, t=2 and DIV_LATENCY=4 at edge 0 -> busy for 4 cycles; at edge 4 HI=3, LO=7; mflo at cycle 5 -> rd_data=7.
REQ-040 Bench: mflo asserted during BUSY -> stall=1 every cycle until completion, then rd_data equals the new LO.
REQ-041 Bench: div_start with t=0 -> dz=1, HI/LO retain prior values after latency; dz_clr -> dz=0; dz_clr together with a new zero divide -> dz stays 1.
REQ-042 Bench: div_start and mul_start together in IDLE -> only the divide is performed; mthi=1 and mtlo=1 with wr_data=32'hA5A5A5A5 in IDLE -> HI=LO=32'hA5A5A5A5.
REQ-043 Bench: reset asserted 2 cycles into a DIV -> busy=0 and HI=LO=0 immediately, with no later update.
REQ-044 Bench: back-to-back mul_start (MUL_LATENCY=1) on consecutive accepted cycles -> each result lands one edge after its start.
